// File: rtl/riscv_approx_dot_seq.sv
// Job sequencer for the approximate ALU: int8 dot product then requantising shift.
// Define APPROX_SEQ_SAT_EN to clamp the final result to signed int8.
module riscv_approx_dot_seq #(
    parameter int LEN_W        = 8,
    parameter int N_BIT_APPR   = 16,
    parameter int N_BIT_PREC   = 16,
    parameter int APP_OP_WIDTH = 7,
    parameter logic [APP_OP_WIDTH-1:0] APP_DOT8     = 7'h50,
    parameter logic [APP_OP_WIDTH-1:0] APP_MULSMACS = 7'h51
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [LEN_W-1:0]        len_i,
    input  logic [4:0]              shift_i,
    input  logic [1:0]              dot_signed_i,
    input  logic [N_BIT_APPR-1:0]   approx_mask_i,
    input  logic [N_BIT_PREC-1:0]   precision_mask_i,
    input  logic                    op_valid_i,
    input  logic [31:0]             op_a_i,
    input  logic [31:0]             op_b_i,
    output logic                    op_ready_o,
    output logic                    alu_enable_o,
    output logic [APP_OP_WIDTH-1:0] alu_operator_o,
    output logic [N_BIT_APPR-1:0]   alu_approx_mask_o,
    output logic [N_BIT_PREC-1:0]   alu_precision_mask_o,
    output logic [31:0]             alu_operand_a_o,
    output logic [31:0]             alu_operand_b_o,
    output logic [31:0]             alu_operand_c_o,
    output logic [1:0]              alu_dot_signed_o,
    output logic [4:0]              alu_imm_o,
    input  logic [31:0]             alu_result_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [31:0]             result_o
);

    typedef enum logic [1:0] {IDLE, RUN, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] cnt;
    logic [4:0]       shift_q;
    logic [31:0]      acc;
    logic             s1_v;
    logic [31:0]      s1_a, s1_b;
    logic             hs;
    logic             job_go;
    logic [31:0]      res_nxt;

    assign op_ready_o = (state == RUN) && (cnt != '0);
    assign hs         = op_valid_i && op_ready_o;
    assign job_go     = (state == IDLE) && start_i && !abort_i;
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE);

`ifdef APPROX_SEQ_SAT_EN
    always_comb begin
        res_nxt = alu_result_i;
        if ($signed(alu_result_i) > 32'sd127)
            res_nxt = 32'd127;
        else if ($signed(alu_result_i) < -32'sd128)
            res_nxt = 32'hFFFF_FF80;
    end
`else
    assign res_nxt = alu_result_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start_i)
                       state_nxt = (len_i != '0) ? RUN : SHIFT;
            RUN:   if (cnt == '0 && !s1_v)
                       state_nxt = SHIFT;
            SHIFT: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_i)
            state_nxt = IDLE;
    end

    // ALU drive comes straight from S1 and the state register
    always_comb begin
        alu_enable_o    = 1'b0;
        alu_operator_o  = '0;
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        alu_operand_c_o = '0;
        alu_imm_o       = '0;
        unique case (1'b1)
            (state == RUN) && s1_v: begin
                alu_enable_o    = 1'b1;
                alu_operator_o  = APP_DOT8;
                alu_operand_a_o = s1_a;
                alu_operand_b_o = s1_b;
                alu_operand_c_o = acc;
            end
            (state == SHIFT): begin
                alu_enable_o    = 1'b1;
                alu_operator_o  = APP_MULSMACS;
                alu_operand_c_o = acc;
                alu_imm_o       = shift_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt                  <= '0;
            shift_q              <= '0;
            acc                  <= '0;
            s1_v                 <= 1'b0;
            s1_a                 <= '0;
            s1_b                 <= '0;
            result_o             <= '0;
            alu_dot_signed_o     <= '0;
            alu_approx_mask_o    <= '0;
            alu_precision_mask_o <= '0;
        end else begin
            if (job_go) begin
                cnt                  <= len_i;
                shift_q              <= shift_i;
                acc                  <= '0;
                alu_dot_signed_o     <= dot_signed_i;
                alu_approx_mask_o    <= approx_mask_i;
                alu_precision_mask_o <= precision_mask_i;
            end
            if (state == RUN) begin
                s1_v <= hs;
                if (hs) begin
                    s1_a <= op_a_i;
                    s1_b <= op_b_i;
                    cnt  <= cnt - 1'b1;
                end
                if (s1_v)
                    acc <= alu_result_i;
            end
            if (state == SHIFT && !abort_i)
                result_o <= res_nxt;
            if (abort_i)
                s1_v <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_approx_dot_seq.sv
// Scoreboard bench for riscv_approx_dot_seq with a behavioural approx ALU model.
// Expected job results are queued at start and checked on each done_o pulse.
module tb_riscv_approx_dot_seq;

    localparam logic [6:0] OP_DOT8 = 7'h50;
    localparam logic [6:0] OP_MACS = 7'h51;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [7:0]  len_i = '0;
    logic [4:0]  shift_i = '0;
    logic [1:0]  dot_signed_i = '0;
    logic [15:0] approx_mask_i = '0;
    logic [15:0] precision_mask_i = '0;
    logic        op_valid_i = 1'b0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        op_ready_o;
    logic        alu_enable_o;
    logic [6:0]  alu_operator_o;
    logic [15:0] alu_approx_mask_o;
    logic [15:0] alu_precision_mask_o;
    logic [31:0] alu_operand_a_o, alu_operand_b_o, alu_operand_c_o;
    logic [1:0]  alu_dot_signed_o;
    logic [4:0]  alu_imm_o;
    logic [31:0] alu_result_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    bit rdy_seen = 0;
    logic [31:0] sb[$];
    logic [31:0] beat_a[0:7];
    logic [31:0] beat_b[0:7];

    riscv_approx_dot_seq dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .len_i(len_i), .shift_i(shift_i), .dot_signed_i(dot_signed_i),
        .approx_mask_i(approx_mask_i), .precision_mask_i(precision_mask_i),
        .op_valid_i(op_valid_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .op_ready_o(op_ready_o), .alu_enable_o(alu_enable_o),
        .alu_operator_o(alu_operator_o),
        .alu_approx_mask_o(alu_approx_mask_o),
        .alu_precision_mask_o(alu_precision_mask_o),
        .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
        .alu_operand_c_o(alu_operand_c_o), .alu_dot_signed_o(alu_dot_signed_o),
        .alu_imm_o(alu_imm_o), .alu_result_i(alu_result_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dot8(logic [31:0] a, logic [31:0] b,
                                         logic [1:0] sg);
        logic [31:0] s = '0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0]  ab = a[8*i +: 8];
            logic [7:0]  bb = b[8*i +: 8];
            logic [31:0] ea = sg[1] ? {{24{ab[7]}}, ab} : {24'd0, ab};
            logic [31:0] eb = sg[0] ? {{24{bb[7]}}, bb} : {24'd0, bb};
            s = s + ea * eb;
        end
        return s;
    endfunction

    // Behavioural approx ALU: exact DOT8 and MULSMACS
    always_comb begin
        alu_result_i = '0;
        if (alu_enable_o && alu_operator_o == OP_DOT8)
            alu_result_i = alu_operand_c_o +
                dot8(alu_operand_a_o, alu_operand_b_o, alu_dot_signed_o);
        else if (alu_enable_o && alu_operator_o == OP_MACS)
            alu_result_i = ($signed(alu_operand_a_o) * $signed(alu_operand_b_o)
                + $signed(alu_operand_c_o)) >>> alu_imm_o;
    end

    function automatic logic [31:0] ref_job(int len, logic [4:0] sh,
                                            logic [1:0] sg);
        logic [31:0] acc = '0;
        for (int i = 0; i < len; i++)
            acc = acc + dot8(beat_a[i], beat_b[i], sg);
        acc = $signed(acc) >>> sh;
`ifdef APPROX_SEQ_SAT_EN
        if ($signed(acc) > 127) acc = 32'd127;
        else if ($signed(acc) < -128) acc = 32'hFFFF_FF80;
`endif
        return acc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (op_ready_o) rdy_seen = 1;
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            if (sb.size() == 0)
                chk("unexpected_done", 32'd1, 32'd0);
            else
                chk("result", result_o, sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int len, input logic [4:0] sh,
                           input logic [1:0] sg, input bit bub,
                           input bit poke, input int exp_lat);
        int idx = 0;
        int k = 0;
        int d0;
        int t0;
        bit hs;
        start_i = 1;
        len_i = len[7:0];
        shift_i = sh;
        dot_signed_i = sg;
        sb.push_back(ref_job(len, sh, sg));
        d0 = done_cnt;
        step();
        start_i = 0;
        t0 = cyc;
        while (idx < len && k < 200) begin
            op_valid_i = bub ? (k % 2 == 0) : 1'b1;
            op_a_i = beat_a[idx];
            op_b_i = beat_b[idx];
            start_i = poke && (k == 2);
            len_i = start_i ? 8'd9 : len[7:0];
            hs = op_valid_i && op_ready_o;
            step();
            if (hs) idx++;
            k++;
        end
        op_valid_i = 0;
        start_i = 0;
        if (idx < len) chk("beats_timeout", idx, len);
        k = 0;
        while (done_cnt == d0 && k < 30) begin
            step();
            k++;
        end
        chk("done_seen", done_cnt - d0, 1);
        if (exp_lat > 0) chk("latency", done_cyc - t0, exp_lat);
        step();
        chk("idle_after", busy_o, 0);
    endtask

    initial begin
        logic [31:0] r;
        int d0;
        #2;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_ready", op_ready_o, 0);
        chk("rst_en", alu_enable_o, 0);
        chk("rst_opc", alu_operand_c_o, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        step();

        beat_a[0] = 32'h01010101; beat_b[0] = 32'h02020202;
        beat_a[1] = 32'hFFFFFFFF; beat_b[1] = 32'h01010101;
        run_job(2, 5'd0, 2'b11, 0, 0, 5);
        chk("job1_value", result_o, 32'd4);

        rdy_seen = 0;
        run_job(0, 5'd3, 2'b11, 0, 0, 0);
        chk("len0_result", result_o, 32'd0);
        chk("len0_no_ready", rdy_seen, 0);

        for (int i = 0; i < 4; i++) begin
            beat_a[i] = 32'h7F7F7F7F;
            beat_b[i] = 32'h7F7F7F7F;
        end
        approx_mask_i = 16'hA5A5;
        precision_mask_i = 16'h5A5A;
        run_job(3, 5'd4, 2'b11, 1, 0, 0);
        chk("appr_mask", alu_approx_mask_o, 16'hA5A5);
        chk("prec_mask", alu_precision_mask_o, 16'h5A5A);
        approx_mask_i = 0;
        precision_mask_i = 0;

        // abort after one accepted beat of four
        r = result_o;
        d0 = done_cnt;
        start_i = 1; len_i = 4; shift_i = 0; dot_signed_i = 2'b11;
        step();
        start_i = 0;
        op_valid_i = 1; op_a_i = 32'h01010101; op_b_i = 32'h01010101;
        step();
        op_valid_i = 0;
        abort_i = 1;
        step();
        abort_i = 0;
        chk("abort_busy", busy_o, 0);
        chk("abort_result", result_o, r);
        repeat (8) step();
        chk("abort_no_done", done_cnt - d0, 0);

        beat_a[0] = 32'h80FF0203; beat_b[0] = 32'h02030405;
        beat_a[1] = 32'h11223344; beat_b[1] = 32'hFEDCBA98;
        beat_a[2] = 32'h7F808182; beat_b[2] = 32'h01FF02FE;
        run_job(3, 5'd1, 2'b10, 0, 1, 6);
        run_job(2, 5'd0, 2'b00, 1, 0, 0);

        start_i = 1; abort_i = 1; len_i = 2;
        step();
        start_i = 0; abort_i = 0;
        chk("start_abort_idle", busy_o, 0);

        // async reset in the middle of a job
        start_i = 1; len_i = 4; dot_signed_i = 2'b11;
        step();
        start_i = 0;
        op_valid_i = 1;
        step();
        step();
        op_valid_i = 0;
        #2 rst = 1;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_en", alu_enable_o, 0);
        chk("arst_ready", op_ready_o, 0);
        chk("arst_result", result_o, 0);
        chk("arst_opc", alu_operand_c_o, 0);
        step();
        rst = 0;
        step();
        chk("arst_idle", busy_o, 0);

        beat_a[0] = 32'h01010101; beat_b[0] = 32'h02020202;
        beat_a[1] = 32'hFFFFFFFF; beat_b[1] = 32'h01010101;
        run_job(2, 5'd0, 2'b11, 0, 0, 5);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
